// File: rtl/classifier_topic_lookup.sv
// classifier_topic_lookup: two-choice (cuckoo) topic lookup engine.
// Hashes a topic key into two bucket indices, reads both hash-table buckets,
// fetches the stored key and expiry time of the first valid bucket, compares,
// and falls back to the second bucket on a miss. One lookup in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_key      lookup request (ready only when idle)
//   cur_time                         free-running time used for expiry check
//   topic_hash_table{0,1}_*          bucket read strobe/address, ack/data back
//   topic_key_*, topic_etime_*       key and etime RAM reads (same address)
//   res_valid/res_ready              result handshake, result held until taken
//   res_hit, res_expired, res_tid    lookup result (tid 0 on miss)
//   stat_*_cnt                       saturating hit/miss/expired counters,
//                                    present only with CLASSIFIER_TOPIC_LOOKUP_STATS_EN
module classifier_topic_lookup #(
    parameter int DEPTH_NBITS       = 12,
    parameter int VALUE_DEPTH_NBITS = 12,
    parameter int KEY_NBITS         = 64,
    parameter int ETIME_NBITS       = 32,
    parameter logic [DEPTH_NBITS-1:0] HASH_SEED = 12'h5A3,
    localparam int BUCKET_NBITS     = VALUE_DEPTH_NBITS + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [KEY_NBITS-1:0]         req_key,
    input  logic [ETIME_NBITS-1:0]       cur_time,
    output logic                         topic_hash_table0_rd,
    output logic [DEPTH_NBITS-1:0]       topic_hash_table0_raddr,
    input  logic                         topic_hash_table0_ack,
    input  logic [BUCKET_NBITS-1:0]      topic_hash_table0_rdata,
    output logic                         topic_hash_table1_rd,
    output logic [DEPTH_NBITS-1:0]       topic_hash_table1_raddr,
    input  logic                         topic_hash_table1_ack,
    input  logic [BUCKET_NBITS-1:0]      topic_hash_table1_rdata,
    output logic                         topic_key_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] topic_key_raddr,
    input  logic                         topic_key_ack,
    input  logic [KEY_NBITS-1:0]         topic_key_rdata,
    output logic                         topic_etime_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] topic_etime_raddr,
    input  logic                         topic_etime_ack,
    input  logic [ETIME_NBITS-1:0]       topic_etime_rdata,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_hit,
    output logic                         res_expired,
    output logic [VALUE_DEPTH_NBITS-1:0] res_tid
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
    ,
    output logic [31:0]                  stat_hit_cnt,
    output logic [31:0]                  stat_miss_cnt,
    output logic [31:0]                  stat_expired_cnt
`endif
);
    localparam int NCHUNK = (KEY_NBITS + DEPTH_NBITS - 1) / DEPTH_NBITS;
    localparam int VB     = VALUE_DEPTH_NBITS;

    typedef enum logic [3:0] {
        IDLE, HT_RD, HT_WAIT, K0_RD, K0_WAIT, CMP0, K1_RD, K1_WAIT, CMP1, DONE
    } state_t;

    state_t                    state, nxt;
    logic [KEY_NBITS-1:0]      key_q, kv_q;
    logic [ETIME_NBITS-1:0]    et_q, age;
    logic [BUCKET_NBITS-1:0]   b0_q, b1_q;
    logic [1:0]                ht_seen, k_seen;
    logic                      ht_done, k_done, b0_v, b1_v, match, expired;

    // XOR-fold of the key into DEPTH_NBITS chunks, top chunk zero-padded
    function automatic logic [DEPTH_NBITS-1:0] fold(input logic [KEY_NBITS-1:0] k);
        logic [NCHUNK*DEPTH_NBITS-1:0] p;
        logic [DEPTH_NBITS-1:0]        h;
        p = '0;
        p[KEY_NBITS-1:0] = k;
        h = '0;
        for (int i = 0; i < NCHUNK; i++) h ^= p[i*DEPTH_NBITS +: DEPTH_NBITS];
        return h;
    endfunction

    // A wait state exits in the cycle the last outstanding ack arrives
    assign ht_done = (ht_seen[0] | topic_hash_table0_ack) & (ht_seen[1] | topic_hash_table1_ack);
    assign k_done  = (k_seen[0] | topic_key_ack) & (k_seen[1] | topic_etime_ack);
    assign b0_v    = ht_seen[0] ? b0_q[VB] : topic_hash_table0_rdata[VB];
    assign b1_v    = ht_seen[1] ? b1_q[VB] : topic_hash_table1_rdata[VB];
    assign match   = kv_q == key_q;
    // Wrap-safe: expired once cur_time has reached etime; etime 0 means no lifetime
    assign age     = cur_time - et_q;
    assign expired = (et_q == '0) | ~age[ETIME_NBITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? HT_RD : IDLE;
            HT_RD:   nxt = HT_WAIT;
            HT_WAIT: nxt = !ht_done ? HT_WAIT : b0_v ? K0_RD : b1_v ? K1_RD : DONE;
            K0_RD:   nxt = K0_WAIT;
            K0_WAIT: nxt = k_done ? CMP0 : K0_WAIT;
            CMP0:    nxt = match ? DONE : b1_q[VB] ? K1_RD : DONE;
            K1_RD:   nxt = K1_WAIT;
            K1_WAIT: nxt = k_done ? CMP1 : K1_WAIT;
            CMP1:    nxt = DONE;
            DONE:    nxt = res_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready               = state == IDLE;
        res_valid               = state == DONE;
        topic_hash_table0_rd    = state == HT_RD;
        topic_hash_table1_rd    = state == HT_RD;
        topic_hash_table0_raddr = fold(key_q);
        topic_hash_table1_raddr = fold({key_q[KEY_NBITS/2-1:0], key_q[KEY_NBITS-1:KEY_NBITS/2]}) ^ HASH_SEED;
        topic_key_rd            = state == K0_RD || state == K1_RD;
        topic_etime_rd          = topic_key_rd;
        topic_key_raddr         = state == K1_RD ? b1_q[VB-1:0] : b0_q[VB-1:0];
        topic_etime_raddr       = topic_key_raddr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            kv_q        <= '0;
            et_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            ht_seen     <= '0;
            k_seen      <= '0;
            res_hit     <= 1'b0;
            res_expired <= 1'b0;
            res_tid     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                key_q       <= req_key;
                ht_seen     <= '0;
                res_hit     <= 1'b0;
                res_expired <= 1'b0;
                res_tid     <= '0;
            end
            if (state == HT_WAIT && topic_hash_table0_ack && !ht_seen[0]) begin
                b0_q       <= topic_hash_table0_rdata;
                ht_seen[0] <= 1'b1;
            end
            if (state == HT_WAIT && topic_hash_table1_ack && !ht_seen[1]) begin
                b1_q       <= topic_hash_table1_rdata;
                ht_seen[1] <= 1'b1;
            end
            if (state == K0_RD || state == K1_RD) k_seen <= '0;
            if ((state == K0_WAIT || state == K1_WAIT) && topic_key_ack && !k_seen[0]) begin
                kv_q      <= topic_key_rdata;
                k_seen[0] <= 1'b1;
            end
            if ((state == K0_WAIT || state == K1_WAIT) && topic_etime_ack && !k_seen[1]) begin
                et_q      <= topic_etime_rdata;
                k_seen[1] <= 1'b1;
            end
            if ((state == CMP0 || state == CMP1) && match) begin
                res_hit     <= 1'b1;
                res_expired <= expired;
                res_tid     <= state == CMP0 ? b0_q[VB-1:0] : b1_q[VB-1:0];
            end
        end
    end

`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
    logic fire;
    assign fire = state == DONE && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit_cnt     <= '0;
            stat_miss_cnt    <= '0;
            stat_expired_cnt <= '0;
        end else if (fire) begin
            stat_hit_cnt     <= stat_hit_cnt + 32'(res_hit && !(&stat_hit_cnt));
            stat_miss_cnt    <= stat_miss_cnt + 32'(!res_hit && !(&stat_miss_cnt));
            stat_expired_cnt <= stat_expired_cnt + 32'(res_expired && !(&stat_expired_cnt));
        end
    end
`endif

endmodule

// File: tb/tb_classifier_topic_lookup.sv
// tb_classifier_topic_lookup: directed bench for classifier_topic_lookup with
// behavioural hash-table / key / etime memories and an independent hash model.
module tb_classifier_topic_lookup;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [63:0] req_key = '0;
    logic [31:0] cur_time = '0;
    logic        t0_rd, t1_rd, t0_ack = 1'b0, t1_ack = 1'b0;
    logic [11:0] t0_raddr, t1_raddr;
    logic [12:0] t0_rdata = '0, t1_rdata = '0;
    logic        key_rd, et_rd, key_ack = 1'b0, et_ack = 1'b0;
    logic [11:0] key_raddr, et_raddr;
    logic [63:0] key_rdata = '0;
    logic [31:0] et_rdata = '0;
    logic        res_valid, res_ready = 1'b0, res_hit, res_expired;
    logic [11:0] res_tid;
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
    logic [31:0] stat_hit_cnt, stat_miss_cnt, stat_expired_cnt;
`endif

    logic [12:0] t0_mem [4096];
    logic [12:0] t1_mem [4096];
    logic [63:0] key_mem [4096];
    logic [31:0] et_mem [4096];
    int          tdly0 = 1, tdly1 = 1, kdly = 1, edly = 1;
    int          n_key_rd = 0, n_et_rd = 0;
    logic [11:0] last_t0 = '0, last_t1 = '0, last_key = '0, last_et = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    classifier_topic_lookup dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .cur_time(cur_time),
        .topic_hash_table0_rd(t0_rd), .topic_hash_table0_raddr(t0_raddr),
        .topic_hash_table0_ack(t0_ack), .topic_hash_table0_rdata(t0_rdata),
        .topic_hash_table1_rd(t1_rd), .topic_hash_table1_raddr(t1_raddr),
        .topic_hash_table1_ack(t1_ack), .topic_hash_table1_rdata(t1_rdata),
        .topic_key_rd(key_rd), .topic_key_raddr(key_raddr),
        .topic_key_ack(key_ack), .topic_key_rdata(key_rdata),
        .topic_etime_rd(et_rd), .topic_etime_raddr(et_raddr),
        .topic_etime_ack(et_ack), .topic_etime_rdata(et_rdata),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_expired(res_expired), .res_tid(res_tid)
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
        , .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt), .stat_expired_cnt(stat_expired_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit i of the key lands on hash bit i mod 12
    function automatic logic [11:0] h0m(input logic [63:0] k);
        logic [11:0] h = '0;
        for (int i = 0; i < 64; i++) h[i % 12] ^= k[i];
        return h;
    endfunction

    function automatic logic [11:0] h1m(input logic [63:0] k);
        return h0m({k[31:0], k[63:32]}) ^ 12'h5A3;
    endfunction

    initial begin : resp_t0
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (t0_rd) begin
                a = t0_raddr;
                last_t0 = a;
                repeat (tdly0) @(posedge clk);
                #1 t0_ack = 1'b1; t0_rdata = t0_mem[a];
                @(posedge clk);
                #1 t0_ack = 1'b0;
            end
        end
    end

    initial begin : resp_t1
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (t1_rd) begin
                a = t1_raddr;
                last_t1 = a;
                repeat (tdly1) @(posedge clk);
                #1 t1_ack = 1'b1; t1_rdata = t1_mem[a];
                @(posedge clk);
                #1 t1_ack = 1'b0;
            end
        end
    end

    initial begin : resp_key
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (key_rd) begin
                a = key_raddr;
                last_key = a;
                n_key_rd++;
                repeat (kdly) @(posedge clk);
                #1 key_ack = 1'b1; key_rdata = key_mem[a];
                @(posedge clk);
                #1 key_ack = 1'b0;
            end
        end
    end

    initial begin : resp_et
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (et_rd) begin
                a = et_raddr;
                last_et = a;
                n_et_rd++;
                repeat (edly) @(posedge clk);
                #1 et_ack = 1'b1; et_rdata = et_mem[a];
                @(posedge clk);
                #1 et_ack = 1'b0;
            end
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < 4096; i++) begin
            t0_mem[i] = '0;
            t1_mem[i] = '0;
        end
    endtask

    // One lookup: result checked on arrival and on every cycle it is held
    task automatic run(input string tag, input logic [63:0] k, input logic [31:0] ct, input int hold,
                       input logic ehit, input logic [11:0] etid, input logic eexp, input int elat);
        int lat = 0;
        @(negedge clk);
        n_key_rd = 0;
        n_et_rd = 0;
        req_key = k;
        cur_time = ct;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (elat >= 0) chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_h0"}, 64'(last_t0), 64'(h0m(k)));
        chk({tag, "_h1"}, 64'(last_t1), 64'(h1m(k)));
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_hit"}, 64'(res_hit), 64'(ehit));
            chk({tag, "_tid"}, 64'(res_tid), 64'(etid));
            chk({tag, "_exp"}, 64'(res_expired), 64'(eexp));
            chk({tag, "_busy"}, 64'({res_valid, req_ready}), 64'b10);
            if (i < hold) begin
                @(posedge clk);
                #1;
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, "_idle"}, 64'({res_valid, req_ready}), 64'b01);
    endtask

    localparam logic [63:0] KA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KB = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] KC = 64'h1111_2222_3333_4444;
    localparam logic [63:0] KD = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] KE = 64'h0F0F_F0F0_5555_AAAA;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        clear_tables();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_valid", 64'({req_ready, res_valid}), 64'b10);
        chk("rst_strobes", 64'({t0_rd, t1_rd, key_rd, et_rd}), 64'd0);
        chk("rst_res", 64'({res_hit, res_expired, res_tid}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // bucket0 hit, live entry
        t0_mem[h0m(KA)] = {1'b1, 12'd5};
        key_mem[5] = KA;
        et_mem[5] = 32'd100;
        run("b0hit", KA, 32'd50, 0, 1'b1, 12'd5, 1'b0, 5);
        chk("b0hit_nkey", 64'(n_key_rd), 64'd1);
        chk("b0hit_addr", 64'({last_key, last_et}), 64'({12'd5, 12'd5}));

        // bucket0 invalid, bucket1 hit: only tid 9 fetched
        clear_tables();
        t1_mem[h1m(KB)] = {1'b1, 12'd9};
        key_mem[9] = KB;
        et_mem[9] = 32'd1000;
        run("b1hit", KB, 32'd10, 0, 1'b1, 12'd9, 1'b0, -1);
        chk("b1hit_nkey", 64'(n_key_rd), 64'd1);
        chk("b1hit_addr", 64'(last_key), 64'd9);

        // both invalid: miss with no key/etime traffic
        clear_tables();
        run("miss_inv", KC, 32'd10, 0, 1'b0, 12'd0, 1'b0, -1);
        chk("miss_inv_nrd", 64'(n_key_rd + n_et_rd), 64'd0);

        // wrapped time, etime ack later than key ack
        clear_tables();
        edly = 3;
        t0_mem[h0m(KD)] = {1'b1, 12'd7};
        key_mem[7] = KD;
        et_mem[7] = 32'hFFFF_FFF0;
        run("wrap", KD, 32'h0000_0010, 0, 1'b1, 12'd7, 1'b1, -1);
        edly = 1;

        // equal time is expired, one tick earlier is live
        et_mem[7] = 32'h0000_1234;
        run("eq", KD, 32'h0000_1234, 0, 1'b1, 12'd7, 1'b1, -1);
        run("early", KD, 32'h0000_1233, 0, 1'b1, 12'd7, 1'b0, -1);
        et_mem[7] = 32'd0;
        run("et0", KD, 32'h0000_0001, 0, 1'b1, 12'd7, 1'b1, -1);

        // bucket0 wrong key, bucket1 hit; table1 acks 3 cycles early; slow consumer
        clear_tables();
        tdly0 = 4;
        t0_mem[h0m(KE)] = {1'b1, 12'd3};
        t1_mem[h1m(KE)] = {1'b1, 12'd11};
        key_mem[3] = KE ^ 64'd1;
        key_mem[11] = KE;
        et_mem[3] = 32'd0;
        et_mem[11] = 32'd500;
        run("b0miss_b1hit", KE, 32'd400, 4, 1'b1, 12'd11, 1'b0, -1);
        tdly0 = 1;
        chk("b0miss_nkey", 64'(n_key_rd), 64'd2);
        chk("b0miss_addr", 64'(last_key), 64'd11);

        // both valid, neither key matches
        key_mem[11] = KE ^ 64'h8000_0000_0000_0000;
        run("miss_both", KE, 32'd400, 0, 1'b0, 12'd0, 1'b0, -1);
        chk("miss_both_nkey", 64'(n_key_rd), 64'd2);

        // both match: bucket0 wins and bucket1 is never fetched
        clear_tables();
        t0_mem[h0m(KA)] = {1'b1, 12'd30};
        t1_mem[h1m(KA)] = {1'b1, 12'd31};
        key_mem[30] = KA;
        key_mem[31] = KA;
        et_mem[30] = 32'd900;
        et_mem[31] = 32'd900;
        run("both_match", KA, 32'd100, 0, 1'b1, 12'd30, 1'b0, 5);
        chk("both_match_nkey", 64'(n_key_rd), 64'd1);

        // reset while waiting on the key RAM
        kdly = 3;
        @(negedge clk);
        req_key = KA;
        cur_time = 32'd100;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!key_rd && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_k0rd", 64'(key_rd), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_state", 64'({req_ready, res_valid}), 64'b10);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rst_noresult", 64'({res_valid, req_ready}), 64'b01);
            @(posedge clk);
            #1;
        end
        kdly = 1;
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
        chk("stat_rst", 64'({stat_hit_cnt, stat_miss_cnt | stat_expired_cnt}), 64'd0);
`endif
        run("post_rst", KA, 32'd100, 0, 1'b1, 12'd30, 1'b0, 5);
`ifdef CLASSIFIER_TOPIC_LOOKUP_STATS_EN
        chk("stat_hit", 64'(stat_hit_cnt), 64'd1);
        chk("stat_miss_exp", 64'({stat_miss_cnt, stat_expired_cnt}), 64'd0);
        run("stat_exp", KA, 32'd900, 0, 1'b1, 12'd30, 1'b1, 5);
        run("stat_miss", KC, 32'd10, 0, 1'b0, 12'd0, 1'b0, -1);
        chk("stat_all", 64'({stat_hit_cnt[15:0], stat_miss_cnt[15:0], stat_expired_cnt[15:0]}),
            64'({16'd2, 16'd1, 16'd1}));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
